burst_dram: RTL and testbench
=============================

Name: burst_dram

Overview:
- Parametrised, single-clock, synthesizable successor to the CVP14 testbench DRAM model.
- Adds multi-beat bursts for vector lanes, a configurable read latency, and explicit Busy, Valid, Done and Err handshakes.
- Sits between the CVP14 load/store unit and backing memory; a scalar access is a burst of length 1.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 16, address port width.
- DEPTH, 1024, number of words; all addresses are taken modulo DEPTH.
- RD_LAT, 2, cycles from a read beat's issue to its data on DataOut; legal range 1..4.
- BURST_MAX, 16, maximum beats per burst; matches vector lane count.

Ports:
- Clk1  in  1  sole clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Addr  in  ADDR_W  burst start address, sampled at acceptance.
- RD  in  1  read request.
- WR  in  1  write request.
- BurstLen  in  $clog2(BURST_MAX)+1  beat count, sampled at acceptance.
- DataIn  in  DATA_W  write data, one word per beat.
- DataOut  out  DATA_W  read data; 0 whenever Valid=0.
- Valid  out  1  DataOut holds a read beat.
- Busy  out  1  request in progress; RD/WR are ignored while high.
- Done  out  1  one-cycle pulse marking burst completion.
- Err  out  1  one-cycle pulse: RD and WR were both high at a sampling edge.

Behaviour:
- Reset values: DataOut=0, Valid=0, Busy=0, Done=0, Err=0.
- Reset returns the FSM to IDLE. Memory contents are unaffected by Reset and are initialised to 0 at time 0.
- FSM states:
  - IDLE -> RBURST on RD&~WR.
  - IDLE -> WBURST on WR&~RD.
  - RBURST -> IDLE after the final beat's Valid cycle.
  - WBURST -> IDLE after the final beat is written.
- Acceptance: a request is accepted at edge T0 where Busy=0, Reset=0 and exactly one of RD/WR is high.
- RD&WR high together at such an edge: no access is performed; Err=1 for the following cycle.
- Effective length L:
  - BurstLen=0 -> L=1.
  - BurstLen>BURST_MAX -> L=BURST_MAX.
  - Otherwise L=BurstLen.
- Beat addresses: beat i uses (Addr+i) mod DEPTH, wrapping from DEPTH-1 to 0.
- Read burst:
  - Beat i is issued at edge T0+i.
  - Valid=1 with the word on DataOut in the cycle after edge T0+i+RD_LAT-1, so L consecutive Valid cycles.
  - Done=1 in the final Valid cycle.
  - Busy=1 from after T0 through the cycle before the final Valid cycle; Busy=0 in the Done cycle.
  - A new request may be accepted at the edge ending the Done cycle.
- Write burst:
  - DataIn is sampled and written for beat i at edge T0+i.
  - Busy=1 for cycles after T0 .. T0+L-2, i.e. L-1 cycles; Busy is never high when L=1.
  - Done=1 in the cycle after edge T0+L-1, with Busy=0.
- Read-after-write: a read accepted after a write's Done observes the written data.
- Reset mid-burst:
  - Aborts the burst; remaining write beats are not written.
  - In-flight read data is discarded; Valid, Busy and Done are 0 in the next cycle.
- Addr, BurstLen and RD/WR changes after acceptance have no effect on the burst in progress.

Test Plan:
- Write L=1, Addr=5, DataIn=16'hBEEF, then read L=1, Addr=5 -> write Done 1 cycle after accept, Busy stays 0; read Valid+Done 2 cycles after accept, DataOut=16'hBEEF.
- Write L=16, Addr=16'h0100, DataIn=16'h1000+i; read back L=16 -> Busy high 15 cycles on write; 16 consecutive Valid cycles, DataOut=16'h1000..16'h100F, Done on the last.
- Wrap: write L=4 at Addr=1022, then read L=4 at Addr=1022 (DEPTH=1024) -> words land at 1022, 1023, 0, 1; read returns the same order.
- Clamp and zero: BurstLen=0 -> exactly 1 Valid beat; BurstLen=31 -> exactly 16 beats.
- RD=WR=1 at idle -> Err pulse 1 cycle, no Valid, memory unchanged. Toggling RD while Busy -> ignored.
- Reset asserted at beat 3 of a 16-beat read (RD_LAT=2) -> next cycle Valid=0, Busy=0, Done=0; a subsequent read L=1 completes normally.

Source files
------------

// File: rtl/burst_dram_if.sv
// Request/response bundle between the CVP14 load/store unit and burst_dram.
// The master drives requests and write data; the slave returns read data and handshakes.
interface burst_dram_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int BURST_MAX = 16
);
  localparam int LEN_W = $clog2(BURST_MAX) + 1;

  logic [ADDR_W-1:0] Addr;
  logic              RD;
  logic              WR;
  logic [LEN_W-1:0]  BurstLen;
  logic [DATA_W-1:0] DataIn;
  logic [DATA_W-1:0] DataOut;
  logic              Valid;
  logic              Busy;
  logic              Done;
  logic              Err;

  modport master (
    output Addr, RD, WR, BurstLen, DataIn,
    input  DataOut, Valid, Busy, Done, Err
  );

  modport slave (
    input  Addr, RD, WR, BurstLen, DataIn,
    output DataOut, Valid, Busy, Done, Err
  );
endinterface

// File: rtl/burst_dram.sv
// Single-clock burst DRAM model with a fixed-latency read pipeline and Busy/Valid/Done/Err handshakes.
// A scalar access is a burst of length 1; beat addresses wrap modulo DEPTH.
module burst_dram #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int RD_LAT    = 2,
  parameter int BURST_MAX = 16
) (
  input  logic        Clk1,
  input  logic        Reset,
  burst_dram_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(BURST_MAX) + 1;

  typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              wrDone_q, wrDone_d;
  logic              err_q, err_d;

  logic [IDX_W-1:0]  memIdx;
  logic [IDX_W-1:0]  startIdx;
  logic [LEN_W-1:0]  effLen;
  logic              memWe;
  logic              issueRd;
  logic              issueLast;
  logic              canAccept;
  logic              lastOut;

  // Storage is not touched by Reset; contents power up as zero on the target.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] pipeData_q [RD_LAT];
  logic [RD_LAT-1:0] pipeValid_q;
  logic [RD_LAT-1:0] pipeLast_q;

  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(DEPTH - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  assign startIdx = IDX_W'(32'(bus.Addr) % 32'(DEPTH));

  always_comb begin
    if (bus.BurstLen == '0) begin
      effLen = LEN_W'(1);
    end else if (bus.BurstLen > LEN_W'(BURST_MAX)) begin
      effLen = LEN_W'(BURST_MAX);
    end else begin
      effLen = bus.BurstLen;
    end
  end

  // The read Done cycle is not Busy, so a new request can be taken at the edge that ends it.
  assign lastOut   = pipeValid_q[RD_LAT-1] & pipeLast_q[RD_LAT-1];
  assign canAccept = ~Reset & ((state_q == IDLE) | ((state_q == RBURST) & lastOut));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    beat_d    = beat_q;
    memIdx    = idx_q;
    memWe     = 1'b0;
    issueRd   = 1'b0;
    issueLast = 1'b0;
    wrDone_d  = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      RBURST: begin
        if (beat_q != len_q) begin
          issueRd   = 1'b1;
          issueLast = (beat_q == len_q - LEN_W'(1));
          idx_d     = nextIdx(idx_q);
          beat_d    = beat_q + LEN_W'(1);
        end
        if (lastOut) begin
          state_d = IDLE;
        end
      end
      WBURST: begin
        memWe  = ~Reset;
        idx_d  = nextIdx(idx_q);
        beat_d = beat_q + LEN_W'(1);
        if (beat_q == len_q - LEN_W'(1)) begin
          state_d  = IDLE;
          wrDone_d = 1'b1;
        end
      end
      default: begin
      end
    endcase

    // Beat 0 is issued or written on the acceptance edge itself.
    if (canAccept) begin
      if (bus.RD && bus.WR) begin
        err_d = 1'b1;
      end else if (bus.RD || bus.WR) begin
        memIdx = startIdx;
        idx_d  = nextIdx(startIdx);
        len_d  = effLen;
        beat_d = LEN_W'(1);
        if (bus.RD) begin
          issueRd   = 1'b1;
          issueLast = (effLen == LEN_W'(1));
          state_d   = RBURST;
        end else begin
          memWe = 1'b1;
          if (effLen == LEN_W'(1)) begin
            wrDone_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = WBURST;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      wrDone_q    <= 1'b0;
      err_q       <= 1'b0;
      pipeValid_q <= '0;
      pipeLast_q  <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      beat_q         <= beat_d;
      wrDone_q       <= wrDone_d;
      err_q          <= err_d;
      pipeValid_q[0] <= issueRd;
      pipeLast_q[0]  <= issueLast;
      for (int k = RD_LAT - 1; k > 0; k--) begin
        pipeValid_q[k] <= pipeValid_q[k-1];
        pipeLast_q[k]  <= pipeLast_q[k-1];
      end
    end
  end

  always_ff @(posedge Clk1) begin
    pipeData_q[0] <= mem_q[memIdx];
    for (int k = RD_LAT - 1; k > 0; k--) begin
      pipeData_q[k] <= pipeData_q[k-1];
    end
    if (memWe) begin
      mem_q[memIdx] <= bus.DataIn;
    end
  end

  assign bus.Valid   = pipeValid_q[RD_LAT-1];
  assign bus.DataOut = pipeValid_q[RD_LAT-1] ? pipeData_q[RD_LAT-1] : '0;
  assign bus.Done    = wrDone_q | lastOut;
  assign bus.Busy    = (state_q == WBURST) | ((state_q == RBURST) & ~lastOut);
  assign bus.Err     = err_q;
endmodule

// File: tb/tb_burst_dram.sv
// Directed self-checking bench for burst_dram with DEPTH=1024, RD_LAT=2, BURST_MAX=16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_burst_dram;
  logic Clk1 = 1'b0;
  logic Reset;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [15:0] rdQ[$];
  int          nValid;
  int          nDone;
  int          nErr;
  int          busyCnt;
  logic        doneAtEnd;
  logic        busyAtEnd;

  always #5 Clk1 = ~Clk1;

  burst_dram_if #(.DATA_W(16), .ADDR_W(16), .BURST_MAX(16)) bus ();

  burst_dram #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(1024), .RD_LAT(2), .BURST_MAX(16)
  ) dut (
    .Clk1 (Clk1),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  task automatic tick();
    @(posedge Clk1);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [4:0] len, input logic [15:0] din);
    bus.RD       = rd;
    bus.WR       = wr;
    bus.Addr     = addr;
    bus.BurstLen = len;
    bus.DataIn   = din;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Writes `beats` words d0, d0+1, ... starting at addr; returns Busy count and Done/Busy in the final cycle.
  task automatic writeBurst(input logic [15:0] addr, input logic [4:0] len, input int beats,
                            input logic [15:0] d0);
    applyStimulus(1'b0, 1'b1, addr, len, d0);
    tick();
    bus.WR  = 1'b0;
    busyCnt = 0;
    for (int i = 1; i < beats; i++) begin
      if (bus.Busy) busyCnt++;
      bus.DataIn = d0 + 16'(i);
      tick();
    end
    doneAtEnd = bus.Done;
    busyAtEnd = bus.Busy;
    tick();
  endtask

  // Issues a read and collects every Valid word within a fixed cycle window.
  task automatic readBurst(input logic [15:0] addr, input logic [4:0] len, input int window);
    applyStimulus(1'b1, 1'b0, addr, len, 16'h0);
    tick();
    bus.RD = 1'b0;
    rdQ.delete();
    nValid = 0;
    nDone  = 0;
    for (int i = 0; i < window; i++) begin
      if (bus.Valid) begin
        nValid++;
        rdQ.push_back(bus.DataOut);
      end
      if (bus.Done) nDone++;
      tick();
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 16'h0, 5'd0, 16'h0);
    Reset = 1'b1;
    tick();
    tick();
    checkOutput("reset Valid", bus.Valid, 0);
    checkOutput("reset Busy", bus.Busy, 0);
    checkOutput("reset Done", bus.Done, 0);
    checkOutput("reset Err", bus.Err, 0);
    checkOutput("reset DataOut", bus.DataOut, 0);
    Reset = 1'b0;
    tick();

    $display("[TB] scalar write then read at 5");
    applyStimulus(1'b0, 1'b1, 16'd5, 5'd1, 16'hBEEF);
    tick();
    bus.WR = 1'b0;
    checkOutput("w1 Done", bus.Done, 1);
    checkOutput("w1 Busy", bus.Busy, 0);
    tick();
    checkOutput("w1 Done drops", bus.Done, 0);
    applyStimulus(1'b1, 1'b0, 16'd5, 5'd1, 16'h0);
    tick();
    bus.RD = 1'b0;
    checkOutput("r1 Valid early", bus.Valid, 0);
    checkOutput("r1 Busy", bus.Busy, 1);
    tick();
    checkOutput("r1 Valid", bus.Valid, 1);
    checkOutput("r1 Done", bus.Done, 1);
    checkOutput("r1 Busy done cycle", bus.Busy, 0);
    checkOutput("r1 DataOut", bus.DataOut, 16'hBEEF);
    tick();
    checkOutput("r1 Valid after", bus.Valid, 0);
    checkOutput("r1 DataOut zero", bus.DataOut, 0);

    $display("[TB] 16-beat write and read at 0x0100");
    writeBurst(16'h0100, 5'd16, 16, 16'h1000);
    checkOutput("w16 busy cycles", busyCnt, 15);
    checkOutput("w16 Done", doneAtEnd, 1);
    checkOutput("w16 Busy at Done", busyAtEnd, 0);
    applyStimulus(1'b1, 1'b0, 16'h0100, 5'd16, 16'h0);
    tick();
    bus.RD = 1'b0;
    checkOutput("r16 Valid early", bus.Valid, 0);
    checkOutput("r16 Busy early", bus.Busy, 1);
    nErr = 0;
    for (int i = 0; i < 16; i++) begin
      bus.RD   = (i >= 2 && i <= 8) ? 1'(i % 2) : 1'b0;
      bus.WR   = (i == 5);
      bus.Addr = 16'h0300;
      tick();
      if (bus.Err) nErr++;
      checkOutput($sformatf("r16 Valid[%0d]", i), bus.Valid, 1);
      checkOutput($sformatf("r16 DataOut[%0d]", i), bus.DataOut, 16'h1000 + 16'(i));
      checkOutput($sformatf("r16 Done[%0d]", i), bus.Done, (i == 15) ? 1 : 0);
      checkOutput($sformatf("r16 Busy[%0d]", i), bus.Busy, (i == 15) ? 0 : 1);
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 5'd0, 16'h0);
    checkOutput("r16 no Err while busy", nErr, 0);
    nValid = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.Valid) nValid++;
    end
    checkOutput("r16 RD toggles ignored", nValid, 0);

    $display("[TB] wrap around DEPTH");
    writeBurst(16'd1022, 5'd4, 4, 16'hA000);
    readBurst(16'd1022, 5'd4, 8);
    checkOutput("wrap beats", nValid, 4);
    checkOutput("wrap d0", rdQ[0], 16'hA000);
    checkOutput("wrap d1", rdQ[1], 16'hA001);
    checkOutput("wrap d2", rdQ[2], 16'hA002);
    checkOutput("wrap d3", rdQ[3], 16'hA003);
    readBurst(16'd0, 5'd1, 4);
    checkOutput("wrap word at 0", rdQ[0], 16'hA002);
    readBurst(16'd1025, 5'd1, 4);
    checkOutput("addr 1025 mod DEPTH", rdQ[0], 16'hA003);

    $display("[TB] length zero and clamp");
    readBurst(16'h0100, 5'd0, 8);
    checkOutput("len0 beats", nValid, 1);
    checkOutput("len0 data", rdQ[0], 16'h1000);
    checkOutput("len0 Done", nDone, 1);
    readBurst(16'h0100, 5'd31, 24);
    checkOutput("len31 beats", nValid, 16);
    checkOutput("len31 last data", rdQ[15], 16'h100F);
    checkOutput("len31 Done", nDone, 1);

    $display("[TB] RD and WR together");
    applyStimulus(1'b1, 1'b1, 16'd5, 5'd1, 16'h1234);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 5'd0, 16'h0);
    checkOutput("err pulse", bus.Err, 1);
    checkOutput("err Busy", bus.Busy, 0);
    checkOutput("err Valid", bus.Valid, 0);
    tick();
    checkOutput("err one cycle", bus.Err, 0);
    checkOutput("err no Valid", bus.Valid, 0);
    readBurst(16'd5, 5'd1, 4);
    checkOutput("err memory unchanged", rdQ[0], 16'hBEEF);

    $display("[TB] reset during read burst");
    applyStimulus(1'b1, 1'b0, 16'h0100, 5'd16, 16'h0);
    tick();
    bus.RD = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("rst read in progress", bus.Valid, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkOutput("rst Valid", bus.Valid, 0);
    checkOutput("rst Busy", bus.Busy, 0);
    checkOutput("rst Done", bus.Done, 0);
    nValid = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.Valid) nValid++;
      tick();
    end
    checkOutput("rst discarded beats", nValid, 0);
    readBurst(16'd5, 5'd1, 4);
    checkOutput("post-rst read beats", nValid, 1);
    checkOutput("post-rst read data", rdQ[0], 16'hBEEF);
    checkOutput("post-rst read Done", nDone, 1);

    $display("[TB] reset during write burst");
    writeBurst(16'h0203, 5'd1, 1, 16'h5555);
    applyStimulus(1'b0, 1'b1, 16'h0200, 5'd16, 16'h2000);
    tick();
    bus.WR     = 1'b0;
    bus.DataIn = 16'h2001;
    tick();
    bus.DataIn = 16'h2002;
    tick();
    bus.DataIn = 16'h2003;
    Reset      = 1'b1;
    tick();
    Reset = 1'b0;
    checkOutput("wrst Busy", bus.Busy, 0);
    checkOutput("wrst Done", bus.Done, 0);
    tick();
    readBurst(16'h0202, 5'd1, 4);
    checkOutput("wrst beat 2 written", rdQ[0], 16'h2002);
    readBurst(16'h0203, 5'd1, 4);
    checkOutput("wrst beat 3 not written", rdQ[0], 16'h5555);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
